// File: rtl/wave_sequencer_pkg.sv
// wave_seq_pkg: shared states, widths and tone table for the wave sequencer
package wave_seq_pkg;
  localparam int INC_W = 25;
  localparam int ID_W = 2;
  typedef enum logic [1:0] {IDLE, TONE, GAP, DONE} state_t;
  localparam logic [INC_W-1:0] TONE_INC0 = 25'd1000;
  localparam logic [INC_W-1:0] TONE_INC1 = 25'd1260;
  localparam logic [INC_W-1:0] TONE_INC2 = 25'd1500;
  localparam logic [INC_W-1:0] TONE_INC3 = 25'd2000;
  function automatic logic [INC_W-1:0] tone_inc(input logic [ID_W-1:0] id);
    return id == 2'd0 ? TONE_INC0 : id == 2'd1 ? TONE_INC1 : id == 2'd2 ? TONE_INC2 : TONE_INC3;
  endfunction
endpackage

// File: rtl/wave_sequencer_if.sv
// wave_sequencer_if: game FSM to sequencer request/status and wave block drive
interface wave_sequencer_if import wave_seq_pkg::*; #(parameter int MAX_STEPS = 16, parameter int DUR_W = 26) ();
  logic start;
  logic abort;
  logic [4:0] seq_len;
  logic [2*MAX_STEPS-1:0] seq_data;
  logic [DUR_W-1:0] tone_dur;
  logic [DUR_W-1:0] gap_dur;
  logic busy;
  logic done;
  logic [INC_W-1:0] wave_inc;
  logic wave_clr;
  logic [3:0] step_idx;
  logic [ID_W-1:0] tone_id;
  modport master (
    output start, abort, seq_len, seq_data, tone_dur, gap_dur,
    input busy, done, wave_inc, wave_clr, step_idx, tone_id
  );
  modport slave (
    input start, abort, seq_len, seq_data, tone_dur, gap_dur,
    output busy, done, wave_inc, wave_clr, step_idx, tone_id
  );
endinterface

// File: rtl/wave_sequencer_dur_timer.sv
// dur_timer: loadable down-counter that saturates at zero and flags expiry
module dur_timer #(parameter int DUR_W = 26) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  output logic             expired
);
  logic [DUR_W-1:0] cnt;
  // load on state entry, otherwise count down and hold at zero
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: plays a latched list of tone IDs as timed tones with silent gaps
module wave_sequencer import wave_seq_pkg::*; #(
  parameter int MAX_STEPS = 16,
  parameter int DUR_W = 26
) (
  input logic clk,
  input logic reset,
  wave_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [4:0] len_q;
  logic [2*MAX_STEPS-1:0] seq_q;
  logic [DUR_W-1:0] tone_q, gap_q, load_val;
  logic [3:0] step_q, step_n;
  logic [ID_W-1:0] id;
  logic load, expired, accept, last;
  function automatic logic [DUR_W-1:0] dur_m1(input logic [DUR_W-1:0] d);
    return d == '0 ? '0 : d - 1'b1;
  endfunction
  assign accept = state == IDLE && bus.start && !bus.abort;
  assign last = {1'b0, step_q} == len_q - 5'd1;
  assign id = seq_q[{step_q, 1'b0} +: ID_W];
  dur_timer #(.DUR_W(DUR_W)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .expired(expired)
  );
  // state, step and latched operating inputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      step_q <= '0;
      len_q <= '0;
      seq_q <= '0;
      tone_q <= '0;
      gap_q <= '0;
    end else begin
      state <= state_n;
      step_q <= step_n;
      if (accept) begin
        len_q <= bus.seq_len > 5'(MAX_STEPS) ? 5'(MAX_STEPS) : bus.seq_len;
        seq_q <= bus.seq_data;
        tone_q <= bus.tone_dur;
        gap_q <= bus.gap_dur;
      end
    end
  // next state, step and timer load
  always_comb begin
    state_n = state;
    step_n = step_q;
    load = 1'b0;
    load_val = dur_m1(tone_q);
    case (state)
      IDLE: if (accept) begin
        state_n = bus.seq_len == '0 ? DONE : TONE;
        step_n = '0;
        load = 1'b1;
        load_val = dur_m1(bus.tone_dur);
      end
      TONE: if (bus.abort) begin
        state_n = IDLE;
        step_n = '0;
      end else if (expired) begin
        state_n = last ? DONE : gap_q == '0 ? TONE : GAP;
        step_n = last || gap_q != '0 ? step_q : step_q + 4'd1;
        load = !last;
        load_val = gap_q == '0 ? dur_m1(tone_q) : gap_q - 1'b1;
      end
      GAP: if (bus.abort) begin
        state_n = IDLE;
        step_n = '0;
      end else if (expired) begin
        state_n = TONE;
        step_n = step_q + 4'd1;
        load = 1'b1;
      end
      default: begin
        state_n = IDLE;
        step_n = '0;
      end
    endcase
  end
  assign bus.busy = state == TONE || state == GAP;
  assign bus.done = state == DONE;
  assign bus.wave_clr = state != TONE;
  assign bus.wave_inc = state == TONE ? tone_inc(id) : '0;
  assign bus.step_idx = step_q;
  assign bus.tone_id = state == TONE ? id : '0;
endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: randomized and directed checks against a cycle-trace model
module tb_wave_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  wave_sequencer_if #(.MAX_STEPS(16), .DUR_W(26)) bus ();
  wave_sequencer #(.MAX_STEPS(16), .DUR_W(26)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  int tone_tab[4] = '{1000, 1260, 1500, 2000};
  typedef struct packed {
    logic busy;
    logic done;
    logic clr;
    logic [24:0] inc;
    logic [3:0] step;
    logic [1:0] id;
    logic chk;
  } rec_t;
  rec_t exp_q[$];
  localparam rec_t IDLE_REC = '{busy: 1'b0, done: 1'b0, clr: 1'b1, inc: '0, step: '0, id: '0, chk: 1'b1};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t obs(input logic chk);
    rec_t r;
    r.busy = bus.busy;
    r.done = bus.done;
    r.clr = bus.wave_clr;
    r.inc = bus.wave_inc;
    r.step = chk ? bus.step_idx : 4'd0;
    r.id = chk ? bus.tone_id : 2'd0;
    r.chk = chk;
    return r;
  endfunction

  task automatic build(input int len, input logic [31:0] data, input int td, input int gd);
    int n;
    rec_t r;
    logic [1:0] tid;
    exp_q.delete();
    n = len > 16 ? 16 : len;
    for (int i = 0; i < n; i++) begin
      tid = data[2*i +: 2];
      for (int c = 0; c < (td == 0 ? 1 : td); c++) begin
        r = '{busy: 1'b1, done: 1'b0, clr: 1'b0, inc: 25'(tone_tab[tid]), step: 4'(i), id: tid, chk: 1'b1};
        exp_q.push_back(r);
      end
      if (i < n - 1)
        for (int c = 0; c < gd; c++) begin
          r = '{busy: 1'b1, done: 1'b0, clr: 1'b1, inc: '0, step: '0, id: '0, chk: 1'b0};
          exp_q.push_back(r);
        end
    end
    r = '{busy: 1'b0, done: 1'b1, clr: 1'b1, inc: '0, step: '0, id: '0, chk: 1'b0};
    exp_q.push_back(r);
  endtask

  task automatic run_checked(input string name, input int len, input logic [31:0] data,
                             input int td, input int gd, input bit perturb);
    rec_t o;
    build(len, data, td, gd);
    bus.seq_len = 5'(len);
    bus.seq_data = data;
    bus.tone_dur = 26'(td);
    bus.gap_dur = 26'(gd);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      o = obs(exp_q[k].chk);
      tests++;
      if (o !== exp_q[k]) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, o, exp_q[k]);
      end
      if (perturb && k < exp_q.size() - 1) begin
        bus.start = 1'($urandom);
        bus.seq_data = $urandom;
        bus.seq_len = 5'($urandom_range(0, 20));
        bus.tone_dur = 26'($urandom_range(0, 5));
        bus.gap_dur = 26'($urandom_range(0, 5));
      end else bus.start = 1'b0;
      tick();
    end
    o = obs(1'b1);
    tests++;
    if (o !== IDLE_REC) begin
      fails++;
      $display("FAIL %s idle after: got %h expected %h", name, o, IDLE_REC);
    end
  endtask

  task automatic test_reset;
    rec_t o;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.seq_len = '0;
    bus.seq_data = '0;
    bus.tone_dur = '0;
    bus.gap_dur = '0;
    tick();
    tick();
    o = obs(1'b1);
    tests++;
    if (o !== IDLE_REC) begin
      fails++;
      $display("FAIL reset: got %h expected %h", o, IDLE_REC);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    run_checked("basic", 2, 32'hD, 3, 2, 1'b0);
    run_checked("no_gap", 3, 32'h20, 1, 0, 1'b0);
    run_checked("empty", 0, $urandom, 3, 2, 1'b0);
    run_checked("tone_dur0", 3, $urandom, 0, 1, 1'b0);
    run_checked("clamp", 20, $urandom, 1, 0, 1'b0);
    run_checked("protect", 4, $urandom, 2, 2, 1'b1);
  endtask

  task automatic test_abort;
    rec_t o;
    build(3, 32'h1B, 2, 3);
    bus.seq_len = 5'd3;
    bus.seq_data = 32'h1B;
    bus.tone_dur = 26'd2;
    bus.gap_dur = 26'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o = obs(exp_q[k].chk);
      tests++;
      if (o !== exp_q[k]) begin
        fails++;
        $display("FAIL abort lead cycle %0d: got %h expected %h", k, o, exp_q[k]);
      end
      if (k == 3) bus.abort = 1'b1;
      tick();
    end
    bus.abort = 1'b0;
    o = obs(1'b1);
    tests++;
    if (o !== IDLE_REC) begin
      fails++;
      $display("FAIL abort idle: got %h expected %h", o, IDLE_REC);
    end
    run_checked("restart", 2, $urandom, 2, 1, 1'b0);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    o = obs(1'b1);
    tests++;
    if (o !== IDLE_REC) begin
      fails++;
      $display("FAIL abort_beats_start: got %h expected %h", o, IDLE_REC);
    end
  endtask

  task automatic test_reset_mid;
    rec_t o;
    build(2, 32'h7, 5, 1);
    bus.seq_len = 5'd2;
    bus.seq_data = 32'h7;
    bus.tone_dur = 26'd5;
    bus.gap_dur = 26'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      o = obs(exp_q[k].chk);
      tests++;
      if (o !== exp_q[k]) begin
        fails++;
        $display("FAIL reset_mid lead cycle %0d: got %h expected %h", k, o, exp_q[k]);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      o = obs(1'b1);
      tests++;
      if (o !== IDLE_REC) begin
        fails++;
        $display("FAIL reset_mid idle %0d: got %h expected %h", k, o, IDLE_REC);
      end
      tick();
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 25; r++)
      run_checked("random", int'($urandom_range(0, 20)), $urandom, int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 3)), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
Controller that plays a Simon tone sequence on the wave accumulator datapath. It latches a packed list of up to MAX_STEPS 2-bit tone IDs and looks each ID up in a fixed tone table to get a phase increment. Each tone is driven onto the wave block's increment input for a programmable duration, separated by silent gaps, with a start/busy/done handshake to the game FSM. During gaps and idle it holds the wave block cleared through wave_clr.

Parameters:
MAX_STEPS, 16, maximum tones per sequence; seq_data width is 2*MAX_STEPS.
DUR_W, 26, width of the tone and gap duration counters, in clk cycles.

Ports:
clk  input  1  system clock (CLOCK_50 at top).
reset  input  1  synchronous, active-high reset.
start  input  1  request to play; sampled only in IDLE.
abort  input  1  stop playback; return to IDLE.
seq_len  input  5  number of tones to play, 0..MAX_STEPS.
seq_data  input  2*MAX_STEPS  tone IDs; step i is bits [2i+1:2i].
tone_dur  input  DUR_W  cycles each tone is held.
gap_dur  input  DUR_W  silent cycles between tones.
busy  output  1  high in TONE and GAP.
done  output  1  one-cycle pulse when the sequence completes.
wave_inc  output  25  increment to the wave block; 0 when silent.
wave_clr  output  1  drives the wave block's reset; high when silent.
step_idx  output  4  index of the current step.
tone_id  output  2  ID of the current tone, for LED echo.

Behaviour:
- All outputs are registered and change on the same edge as the state.
- Reset values: state IDLE, busy=0, done=0, wave_inc=0, wave_clr=1, step_idx=0, tone_id=0.
- Reset applies at any time, including mid-sequence: next cycle is IDLE with the reset values and no done pulse.
- State IDLE:
  - start=1 with seq_len>0: latch seq_data, seq_len, tone_dur and gap_dur, then go to TONE with step 0.
  - start=1 with seq_len=0: go straight to DONE.
  - Otherwise stay in IDLE.
- State TONE:
  - busy=1, wave_clr=0, wave_inc=TONE_INC[id], tone_id=id, where id is the latched seq_data of step_idx.
  - Lasts exactly max(tone_dur,1) cycles.
  - Then: if step_idx==len-1, go to DONE; else if gap_dur==0, go to TONE with step_idx+1 (no silent cycle); else go to GAP.
- State GAP:
  - busy=1, wave_clr=1, wave_inc=0.
  - Lasts exactly gap_dur cycles, then go to TONE with step_idx+1.
- State DONE:
  - done=1, busy=0, wave_clr=1, wave_inc=0.
  - Lasts one cycle, then go to IDLE.
  - start is ignored in DONE.
- There is no trailing gap after the last tone.
- A seq_len above MAX_STEPS is clamped to MAX_STEPS at latch time.
- The operating inputs are used only as latched copies. Changes to them while busy have no effect.
- start while busy is ignored.
- abort=1 in TONE or GAP: next cycle is IDLE, wave_clr=1, wave_inc=0, no done pulse. abort in IDLE or DONE has no effect.
- abort and reset beat start if asserted in the same cycle.
- Duration counter: loaded with duration-1 on state entry, counts down, and exits at 0. There is no wrap-around.
- step_idx resets to 0 in IDLE.

Decomposition:
- Package wave_seq_pkg holds:
  - the state enum {IDLE, TONE, GAP, DONE};
  - the tone table TONE_INC0..3 = 25'd1000, 25'd1260, 25'd1500, 25'd2000;
  - the widths INC_W=25 and ID_W=2.
- One natural sub-module: dur_timer. It is a DUR_W-bit down-counter with load, load value, and an expired flag. It is shared between TONE and GAP.

Test Plan:
- Basic run: seq_len=2, seq_data ids [1,3], tone_dur=3, gap_dur=2, start pulse → wave_inc=1260 for 3 cycles, then 0/clr for 2 cycles, then 2000 for 3 cycles, then done=1 for 1 cycle. busy is high for 8 cycles.
- No gap: seq_len=3, ids [0,0,2], tone_dur=1, gap_dur=0 → wave_inc reads 1000, 1000, 1500 on consecutive cycles, wave_clr stays 0 throughout, done comes on the next cycle.
- Empty and degenerate inputs:
  - seq_len=0 with start → done pulses one cycle after start and busy never rises.
  - tone_dur=0 → each tone lasts 1 cycle.
- Abort and re-start: abort in the 2nd cycle of GAP → IDLE next cycle, no done pulse, wave_clr=1. A new start is accepted the following cycle.
- Protection of latched values:
  - start and changes to seq_data while busy are ignored; the original sequence completes unchanged.
  - seq_len=20 plays exactly 16 tones.
- Reset: reset asserted mid-TONE → next cycle all outputs are at their reset values, with no done pulse.
